// File: rtl/egress_pkg.sv
`default_nettype none
// ============================================================================
// Module      : egress_pkg
// Description : Shared constants and FSM state encoding for the egress
//               arbiter and its output buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package egress_pkg;

  // Default parameter values used by the arbiter
  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_BURST_MAX  = 4;
  localparam int DEFAULT_CNT_WIDTH  = 16;

  // Burst counter width, wide enough for the largest legal burst (15)
  localparam int BURST_W = 4;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE0 = 2'd1,
    SERVE1 = 2'd2
  } egress_state_t;

  // Map a source index onto the matching SERVE state
  function automatic egress_state_t serve_state(input logic src);
    return src ? SERVE1 : SERVE0;
  endfunction

endpackage : egress_pkg
`default_nettype wire

// File: rtl/egress_out_buf.sv
`default_nettype none
// ============================================================================
// Module      : egress_out_buf
// Description : Two-entry in-order buffer of {src, data} words feeding the
//               egress output. Head entry is always presented on the output.
//               The writer guarantees it never writes when full.
// Revision    : 1.0 - initial release
// ============================================================================
module egress_out_buf #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  wr_src,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [1:0]            count,
  output logic                  head_valid,
  output logic                  head_src,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic                  src_q  [2];
  logic [DATA_WIDTH-1:0] data_q [2];
  logic                  head_ptr;
  logic                  tail_ptr;
  logic                  rd_ok;

  // A read is only meaningful when there is a word at the head
  assign rd_ok      = rd_en && (count != 2'd0);
  assign head_valid = (count != 2'd0);
  assign head_src   = src_q[head_ptr];
  assign head_data  = data_q[head_ptr];

  // Storage, pointers and occupancy; reset discards every buffered word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q[0]  <= 1'b0;
      src_q[1]  <= 1'b0;
      data_q[0] <= '0;
      data_q[1] <= '0;
      head_ptr  <= 1'b0;
      tail_ptr  <= 1'b0;
      count     <= 2'd0;
    end else begin
      if (wr_en) begin
        src_q[tail_ptr]  <= wr_src;
        data_q[tail_ptr] <= wr_data;
        tail_ptr         <= ~tail_ptr;
      end
      if (rd_ok) begin
        head_ptr <= ~head_ptr;
      end
      case ({wr_en, rd_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule : egress_out_buf
`default_nettype wire

// File: rtl/egress_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : egress_arbiter
// Description : Bursting round-robin arbiter draining two egress FIFOs into
//               a two-entry ordered output buffer with valid/ready output.
//               Optional per-source delivery counters are built when the
//               macro EGRESS_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module egress_arbiter
  import egress_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int BURST_MAX  = DEFAULT_BURST_MAX,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  empty_e0,
  input  logic                  empty_e1,
  input  logic [DATA_WIDTH-1:0] data_e0,
  input  logic [DATA_WIDTH-1:0] data_e1,
  input  logic                  ready_out,
`ifdef EGRESS_STATS_EN
  output logic [CNT_WIDTH-1:0]  cnt_e0,
  output logic [CNT_WIDTH-1:0]  cnt_e1,
`endif
  output logic                  pop_e0,
  output logic                  pop_e1,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  src_out
);

  localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(BURST_MAX);

  egress_state_t         state;
  egress_state_t         state_nxt;
  logic [BURST_W-1:0]    burst;
  logic                  burst_clr;
  logic                  last_src;
  logic                  grant_upd;
  logic                  grant_src;
  logic                  inflight;
  logic                  inflight_src;
  logic [1:0]            buf_count;
  logic                  xfer;
  logic [2:0]            fill;
  logic                  space;
  logic [DATA_WIDTH-1:0] wr_data;

  // Words committed to the buffer after this cycle; a new pop must keep it below 2
  assign xfer    = valid_out & ready_out;
  assign fill    = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, xfer};
  assign space   = (fill < 3'd2);
  assign wr_data = inflight_src ? data_e1 : data_e0;

  egress_out_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_buf (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (inflight),
    .wr_src     (inflight_src),
    .wr_data    (wr_data),
    .rd_en      (xfer),
    .count      (buf_count),
    .head_valid (valid_out),
    .head_src   (src_out),
    .head_data  (data_out)
  );

  // Next-state, pop strobes and grant bookkeeping
  always_comb begin
    state_nxt = state;
    pop_e0    = 1'b0;
    pop_e1    = 1'b0;
    burst_clr = 1'b0;
    grant_upd = 1'b0;
    grant_src = last_src;
    case (state)
      IDLE: begin
        // With both pending, the source not served last wins
        if (!empty_e0 && (empty_e1 || last_src)) begin
          state_nxt = SERVE0;
          grant_upd = 1'b1;
          grant_src = 1'b0;
          burst_clr = 1'b1;
        end else if (!empty_e1) begin
          state_nxt = SERVE1;
          grant_upd = 1'b1;
          grant_src = 1'b1;
          burst_clr = 1'b1;
        end
      end
      SERVE0: begin
        if ((burst == BURST_LIM) || empty_e0) begin
          burst_clr = 1'b1;
          if (!empty_e1) begin
            state_nxt = serve_state(1'b1);
            grant_upd = 1'b1;
            grant_src = 1'b1;
          end else if (!empty_e0) begin
            state_nxt = serve_state(1'b0);
            grant_upd = 1'b1;
            grant_src = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          pop_e0 = space;
        end
      end
      SERVE1: begin
        if ((burst == BURST_LIM) || empty_e1) begin
          burst_clr = 1'b1;
          if (!empty_e0) begin
            state_nxt = serve_state(1'b0);
            grant_upd = 1'b1;
            grant_src = 1'b0;
          end else if (!empty_e1) begin
            state_nxt = serve_state(1'b1);
            grant_upd = 1'b1;
            grant_src = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          pop_e1 = space;
        end
      end
      default: begin
        state_nxt = IDLE;
        burst_clr = 1'b1;
      end
    endcase
  end

  // State, burst count, last grant and the in-flight pop marker
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      burst        <= '0;
      last_src     <= 1'b1;
      inflight     <= 1'b0;
      inflight_src <= 1'b0;
    end else begin
      state <= state_nxt;
      if (burst_clr) begin
        burst <= '0;
      end else if (pop_e0 || pop_e1) begin
        burst <= burst + 1'b1;
      end
      if (grant_upd) begin
        last_src <= grant_src;
      end
      inflight     <= pop_e0 | pop_e1;
      inflight_src <= pop_e1;
    end
  end

`ifdef EGRESS_STATS_EN
  // Saturating count of words delivered per source
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_e0 <= '0;
      cnt_e1 <= '0;
    end else if (xfer) begin
      if (!src_out && (cnt_e0 != '1)) begin
        cnt_e0 <= cnt_e0 + 1'b1;
      end
      if (src_out && (cnt_e1 != '1)) begin
        cnt_e1 <= cnt_e1 + 1'b1;
      end
    end
  end
`endif

endmodule : egress_arbiter
`default_nettype wire

// File: doc/egress_arbiter.md
EGRESS_ARBITER -- requirements
Module: egress_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of every data word.
REQ-002 Parameter BURST_MAX, default 4, maximum consecutive pops from one egress FIFO before re-arbitration; legal range 1..15.
REQ-003 Parameter CNT_WIDTH, default 16, width of the statistics counters.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 empty_e0 / empty_e1  input  1 each  egress FIFO 0/1 empty flags.
REQ-007 data_e0 / data_e1  input  DATA_WIDTH each  egress FIFO read data, valid one cycle after the matching pop.
REQ-008 ready_out  input  1  downstream accepts data_out this cycle.
REQ-009 pop_e0 / pop_e1  output  1 each  read strobe to egress FIFO 0/1.
REQ-010 data_out  output  DATA_WIDTH  head word of the output buffer.
REQ-011 valid_out  output  1  data_out holds a word.
REQ-012 src_out  output  1  source FIFO of data_out: 0 = e0, 1 = e1.
REQ-013 cnt_e0 / cnt_e1  output  CNT_WIDTH each  words delivered per source; present only with EGRESS_STATS_EN.

Function
REQ-014 Transfer occurs on a cycle with valid_out=1 and ready_out=1; exactly one word leaves the buffer per transfer.
REQ-015 Output buffer: 2-entry FIFO of {src, data}, in order; valid_out = (occupancy != 0); data_out/src_out = head entry.
REQ-016 Each pop at cycle t writes the selected data_eX into the buffer at the rising edge ending cycle t+1; data_out is visible at t+2 at the earliest.
REQ-017 Pop allowed only if occupancy + in-flight - (transfer this cycle) < 2, so the buffer never overflows.
REQ-018 Pop never issued to a FIFO whose empty flag is 1; pop_e0 and pop_e1 never high in the same cycle.
REQ-019 FSM states IDLE, SERVE0, SERVE1; IDLE->SERVEx when a FIFO is non-empty; in SERVEx, pop_ex = !empty_ex and buffer space available (REQ-017).
REQ-020 Burst counter increments per pop and clears on every state change; SERVEx leaves at burst = BURST_MAX or empty_ex = 1.
REQ-021 On leaving SERVEx: go to the other SERVE state if that FIFO is non-empty, else SERVEx again if still non-empty (burst restarts), else IDLE.
REQ-022 From IDLE with both FIFOs non-empty, grant the FIFO not served last (last_src register); last_src resets to 1, so e0 wins first.
REQ-023 ready_out low stalls transfers only; arbitration state is held, no word is dropped or duplicated.
REQ-024 Simultaneous transfer and buffer write in one cycle keeps occupancy unchanged and preserves order.

Reset
REQ-025 On reset assertion, immediately: pop_e0 = pop_e1 = 0, valid_out = 0, data_out = 0, src_out = 0, FSM = IDLE, burst = 0, buffer and in-flight flag cleared, last_src = 1, cnt_e0 = cnt_e1 = 0.
REQ-026 Any word in flight or buffered when reset asserts is discarded; first pop no earlier than the first rising edge after reset deasserts.

Configuration
REQ-027 Macro EGRESS_STATS_EN defined: cnt_e0/cnt_e1 ports exist and increment by 1 on each transfer with src_out = 0/1, saturating at 2^CNT_WIDTH-1.
REQ-028 EGRESS_STATS_EN undefined: counter ports and logic absent; all other behaviour identical.

Structure
REQ-029 Shared package egress_pkg holds the FSM state encoding (IDLE=2'd0, SERVE0=2'd1, SERVE1=2'd2) and the default DATA_WIDTH/BURST_MAX/CNT_WIDTH constants.
REQ-030 One sub-module, egress_out_buf, implements the 2-entry ordered output buffer; the arbiter FSM stays in egress_arbiter.

Verification
REQ-031 reset=1 for 3 cycles with both FIFOs non-empty -> no pop, valid_out = 0, counters 0; first pop_e0 on the first edge after deassertion.
REQ-032 e1 empty, e0 holds 0x11..0x16, ready_out = 1, BURST_MAX = 4 -> 4 pops, 1 re-grant of SERVE0, 2 pops; data_out 0x11..0x16 in order, src_out = 0.
REQ-033 Both FIFOs hold 8 words, ready_out = 1 -> pop pattern 4x e0, 4x e1, 4x e0, 4x e1; last_src alternates; no cycle with both pops.
REQ-034 ready_out = 0 for 10 cycles during an e0 burst -> at most 2 pops issued, valid_out stays 1, data_out frozen; on ready_out = 1 words resume with no loss or duplication.
REQ-035 Reset pulsed 1 cycle while the buffer holds 2 words and a pop is in flight -> valid_out drops at once, discarded words never appear, e0 served first after release.
REQ-036 EGRESS_STATS_EN, CNT_WIDTH = 4, 20 transfers from e1 -> cnt_e1 saturates at 15, cnt_e0 = 0.
